regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the RV32 core, succeeding the fixed 32x32 file.
- Two combinational read ports and one posedge write port; x0 is hardwired to zero.
- Adds a per-register busy scoreboard for pipeline hazard detection and a post-reset clear sweep.
- Adds a selectable debug read port.
- Sits between decode (reads, issue) and writeback (writes, busy clear).

---
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard, post-reset clear sweep and debug read port.
// Optional write-through forwarding on rs1/rs2 is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data,
  input  logic            reg_write,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data,
  output logic            ready
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             clr_we;
  logic             running;
  logic             run_we;
  logic             byp1, byp2;

  logic [XLEN-1:0]  mem [NREGS];

  assign running = (state_q == RUN);
  assign ready   = running;
  assign run_we  = running && reg_write && (rd != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Sweep writes one entry per cycle; the edge that writes the last entry enters RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (running) begin
      if (reg_write && (rd != '0))
        busy_d[rd] = 1'b0;
      if (issue_valid && (issue_rd != '0))
        busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (clr_we)
      mem[cnt_q] <= '0;
    else if (run_we)
      mem[rd] <= data;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = run_we && (rd == rs1);
  assign byp2 = run_we && (rd == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (running) begin
      if (rs1 != '0) begin
        rs1_data = byp1 ? data : mem[rs1];
        rs1_busy = busy_q[rs1] && !byp1;
      end
      if (rs2 != '0) begin
        rs2_data = byp2 ? data : mem[rs2];
        rs2_busy = busy_q[rs2] && !byp2;
      end
      if (dbg_sel != '0)
        dbg_data = mem[dbg_sel];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: reset sweep, table-driven read/write/scoreboard vectors, mid-run reset.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic [AW-1:0]   rs1, rs2, rd, issue_rd, dbg_sel;
  logic [XLEN-1:0] rs1_data, rs2_data, data, dbg_data;
  logic            rs1_busy, rs2_busy, reg_write, issue_valid, ready;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clock(clock), .reset_n(reset_n),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .data(data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dsel;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
    logic [31:0] ed;
  } exp_t;

  vec_t vecs[16];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write   = 1'b0;
    rd          = '0;
    data        = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   bad;
    exp_t ex;

    // Expected results after the sweep; each row is sampled before its own clock edge.
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 5'd5,
                 BP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd5, 5'd3,
                 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3,
                 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3,
                 BP ? 32'h33 : 32'h0, BP ? 32'h33 : 32'h0, !BP, !BP, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd5, 5'd3,
                 32'h33, 32'hDEADBEEF, 1'b0, 1'b0, 32'h33};
    vecs[8]  = '{1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd0, 5'd3,
                 BP ? 32'h44 : 32'h33, 32'h0, 1'b0, 1'b0, 32'h33};
    vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3,
                 32'h44, 32'h0, 1'b1, 1'b0, 32'h44};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd3, 5'd0,
                 32'h0, 32'h44, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 5'd3, 32'h55, 1'b1, 5'd6, 5'd0, 5'd3, 5'd3,
                 32'h0, BP ? 32'h55 : 32'h44, 1'b0, !BP, 32'h44};
    vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd3, 5'd0,
                 32'h0, 32'h55, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7,
                 BP ? 32'hA5A5A5A5 : 32'h0, BP ? 32'hA5A5A5A5 : 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[15] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd6, 5'd5,
                 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};

    reset_n = 1'b0;
    idle_inputs();
    rs1 = 5'd5; rs2 = 5'd0; dbg_sel = 5'd5;
    repeat (3) tick();
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_rs1_busy", rs1_busy, 0);
    chk("reset_rs1_data", rs1_data, 0);
    chk("reset_dbg_data", dbg_data, 0);

    // Sweep: ready low for exactly NREGS cycles; a write and issue at sweep cycle 2 are ignored.
    reset_n = 1'b1;
    rs1 = 5'd9;
    bad = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (i == 2) begin
        reg_write = 1'b1; rd = 5'd9; data = 32'hFF;
        issue_valid = 1'b1; issue_rd = 5'd9;
      end
      #1;
      if (ready !== 1'b0) bad++;
      if (i == 2) chk("clear_rs1_data", rs1_data, 0);
      tick();
      idle_inputs();
    end
    chk("sweep_ready_low_cycles", bad, 0);
    #1;
    chk("sweep_ready_high", ready, 1);
    chk("clear_write_x9_data", rs1_data, 0);
    chk("clear_issue_x9_busy", rs1_busy, 0);
    for (int d = 0; d < NREGS; d++) begin
      dbg_sel = d[4:0];
      #1;
      chk($sformatf("sweep_dbg_x%0d", d), dbg_data, 0);
    end
    tick();

    for (int v = 0; v < 16; v++) begin
      reg_write   = vecs[v].we;
      rd          = vecs[v].rd;
      data        = vecs[v].data;
      issue_valid = vecs[v].iv;
      issue_rd    = vecs[v].ird;
      rs1         = vecs[v].r1;
      rs2         = vecs[v].r2;
      dbg_sel     = vecs[v].dsel;
      sbq.push_back('{vecs[v].e1, vecs[v].e2, vecs[v].b1, vecs[v].b2, vecs[v].ed});
      #2;
      ex = sbq.pop_front();
      chk($sformatf("v%0d_rs1_data", v), rs1_data, ex.e1);
      chk($sformatf("v%0d_rs2_data", v), rs2_data, ex.e2);
      chk($sformatf("v%0d_rs1_busy", v), rs1_busy, ex.b1);
      chk($sformatf("v%0d_rs2_busy", v), rs2_busy, ex.b2);
      chk($sformatf("v%0d_dbg_data", v), dbg_data, ex.ed);
      tick();
    end
    idle_inputs();

    // Reset in RUN with x4 busy and holding 0x55.
    reg_write = 1'b1; rd = 5'd4; data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    idle_inputs();
    rs1 = 5'd4; dbg_sel = 5'd4;
    #1;
    chk("pre_reset_x4_busy", rs1_busy, 1);
    chk("pre_reset_x4_data", rs1_data, 32'h55);
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", rs1_busy, 0);
    chk("async_reset_ready", ready, 0);
    tick();
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < NREGS; i++) begin
      #1;
      if (ready !== 1'b0) bad++;
      tick();
    end
    chk("resweep_ready_low_cycles", bad, 0);
    #1;
    chk("resweep_ready_high", ready, 1);
    chk("resweep_x4_data", rs1_data, 0);
    chk("resweep_x4_busy", rs1_busy, 0);
    chk("resweep_x4_dbg", dbg_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
